// File: rtl/clint_pkg.sv
// Shared constants, decode-result types and the address decoder for the CLINT.
// Decoder returns DEC_NONE for unmapped offsets and for hart indices past NR_HARTS.
package clint_pkg;

   localparam logic [15:0] MSIP_BASE     = 16'h0000;
   localparam logic [15:0] MTIMECMP_BASE = 16'h4000;
   localparam logic [15:0] MTIME_OFFSET  = 16'hBFF8;

   localparam logic [1:0]  RESP_OKAY     = 2'b00;
   localparam logic [1:0]  RESP_SLVERR   = 2'b10;

   typedef enum logic [1:0] {DEC_MSIP, DEC_MTIMECMP, DEC_MTIME, DEC_NONE} dec_e;

   typedef struct packed {
      dec_e        sel;
      logic [12:0] idx;
   } dec_t;

   // For msip, idx is the 64-bit word holding harts 2*idx and 2*idx+1.
   function automatic dec_t clint_decode(input logic [15:0] off, input int dw, input int nr_harts);
      dec_t        d;
      logic [15:0] rel_m;
      logic [15:0] rel_c;
      rel_m = off - MSIP_BASE;
      rel_c = off - MTIMECMP_BASE;
      d.sel = DEC_NONE;
      d.idx = '0;
      if (off < MTIMECMP_BASE) begin
         d.idx = rel_m[15:3];
         if ((dw == 64) ? (2 * int'(rel_m[15:3]) < nr_harts) : (int'(rel_m[15:2]) < nr_harts))
            d.sel = DEC_MSIP;
      end else if (off[15:3] == MTIME_OFFSET[15:3]) begin
         d.sel = DEC_MTIME;
      end else if (off < MTIME_OFFSET) begin
         d.idx = rel_c[15:3];
         if (int'(rel_c[15:3]) < nr_harts)
            d.sel = DEC_MTIMECMP;
      end
      return d;
   endfunction

endpackage

// File: rtl/clint_axil_slave.sv
// AXI4-Lite slave front end: one-entry AW/W latches, B/R channel state, and a
// single-cycle register access strobe toward the CLINT register file.
module clint_axil_slave
   import clint_pkg::*;
#(
   parameter int AXI_ADDR_WIDTH = 64,
   parameter int AXI_DATA_WIDTH = 64
) (
   input  logic                          aclk,
   input  logic                          areset,
   input  logic [AXI_ADDR_WIDTH-1:0]     s_axi_awaddr,
   input  logic                          s_axi_awvalid,
   output logic                          s_axi_awready,
   input  logic [AXI_DATA_WIDTH-1:0]     s_axi_wdata,
   input  logic [AXI_DATA_WIDTH/8-1:0]   s_axi_wstrb,
   input  logic                          s_axi_wvalid,
   output logic                          s_axi_wready,
   output logic [1:0]                    s_axi_bresp,
   output logic                          s_axi_bvalid,
   input  logic                          s_axi_bready,
   input  logic [AXI_ADDR_WIDTH-1:0]     s_axi_araddr,
   input  logic                          s_axi_arvalid,
   output logic                          s_axi_arready,
   output logic [AXI_DATA_WIDTH-1:0]     s_axi_rdata,
   output logic [1:0]                    s_axi_rresp,
   output logic                          s_axi_rvalid,
   input  logic                          s_axi_rready,
   output logic                          reg_we,
   output logic [15:0]                   reg_waddr,
   output logic [AXI_DATA_WIDTH-1:0]     reg_wdata,
   output logic [AXI_DATA_WIDTH/8-1:0]   reg_wstrb,
   input  logic                          reg_werr,
   output logic                          reg_re,
   output logic [15:0]                   reg_raddr,
   input  logic [AXI_DATA_WIDTH-1:0]     reg_rdata,
   input  logic                          reg_rerr
);

   logic                        aw_full;
   logic                        w_full;
   logic [15:0]                 aw_addr;
   logic [AXI_DATA_WIDTH-1:0]   w_data;
   logic [AXI_DATA_WIDTH/8-1:0] w_strb;

   // Only the 64 KiB window is decoded.
   logic unused_ok;
   assign unused_ok = ^{s_axi_awaddr, s_axi_araddr};

   // Latches stay closed while a response waits for bready.
   assign s_axi_awready = !aw_full && !s_axi_bvalid;
   assign s_axi_wready  = !w_full && !s_axi_bvalid;
   assign s_axi_arready = !s_axi_rvalid;

   assign reg_we    = aw_full && w_full && !s_axi_bvalid;
   assign reg_waddr = aw_addr;
   assign reg_wdata = w_data;
   assign reg_wstrb = w_strb;
   assign reg_re    = s_axi_arvalid && s_axi_arready;
   assign reg_raddr = s_axi_araddr[15:0];

   always_ff @(posedge aclk) begin
      if (areset) begin
         aw_full      <= 1'b0;
         w_full       <= 1'b0;
         aw_addr      <= '0;
         w_data       <= '0;
         w_strb       <= '0;
         s_axi_bvalid <= 1'b0;
         s_axi_bresp  <= RESP_OKAY;
         s_axi_rvalid <= 1'b0;
         s_axi_rdata  <= '0;
         s_axi_rresp  <= RESP_OKAY;
      end else begin
         if (s_axi_awvalid && s_axi_awready) begin
            aw_full <= 1'b1;
            aw_addr <= s_axi_awaddr[15:0];
         end
         if (s_axi_wvalid && s_axi_wready) begin
            w_full <= 1'b1;
            w_data <= s_axi_wdata;
            w_strb <= s_axi_wstrb;
         end
         if (reg_we) begin
            aw_full      <= 1'b0;
            w_full       <= 1'b0;
            s_axi_bvalid <= 1'b1;
            s_axi_bresp  <= reg_werr ? RESP_SLVERR : RESP_OKAY;
         end else if (s_axi_bvalid && s_axi_bready) begin
            s_axi_bvalid <= 1'b0;
         end
         if (reg_re) begin
            s_axi_rvalid <= 1'b1;
            s_axi_rdata  <= reg_rdata;
            s_axi_rresp  <= reg_rerr ? RESP_SLVERR : RESP_OKAY;
         end else if (s_axi_rvalid && s_axi_rready) begin
            s_axi_rvalid <= 1'b0;
         end
      end
   end

endmodule

// File: rtl/clint_axil.sv
// Core-local interruptor: prescaled 64-bit mtime, per-hart msip/mtimecmp, AXI4-Lite.
// Define CLINT_DECODE_ERR_EN to answer unmapped/out-of-range accesses with SLVERR.
module clint_axil
   import clint_pkg::*;
#(
   parameter int NR_HARTS       = 1,
   parameter int AXI_ADDR_WIDTH = 64,
   parameter int AXI_DATA_WIDTH = 64,
   parameter int RTC_DIV        = 2
) (
   input  logic                          aclk,
   input  logic                          areset,
   input  logic [AXI_ADDR_WIDTH-1:0]     s_axi_awaddr,
   input  logic                          s_axi_awvalid,
   output logic                          s_axi_awready,
   input  logic [AXI_DATA_WIDTH-1:0]     s_axi_wdata,
   input  logic [AXI_DATA_WIDTH/8-1:0]   s_axi_wstrb,
   input  logic                          s_axi_wvalid,
   output logic                          s_axi_wready,
   output logic [1:0]                    s_axi_bresp,
   output logic                          s_axi_bvalid,
   input  logic                          s_axi_bready,
   input  logic [AXI_ADDR_WIDTH-1:0]     s_axi_araddr,
   input  logic                          s_axi_arvalid,
   output logic                          s_axi_arready,
   output logic [AXI_DATA_WIDTH-1:0]     s_axi_rdata,
   output logic [1:0]                    s_axi_rresp,
   output logic                          s_axi_rvalid,
   input  logic                          s_axi_rready,
   output logic [NR_HARTS-1:0]           timer_irq_o,
   output logic [NR_HARTS-1:0]           ipi_o
);

   localparam int DW = AXI_DATA_WIDTH;

   logic                 reg_we;
   logic [15:0]          reg_waddr;
   logic [DW-1:0]        reg_wdata;
   logic [DW/8-1:0]      reg_wstrb;
   logic                 reg_werr;
   logic                 reg_re;
   logic [15:0]          reg_raddr;
   logic [DW-1:0]        reg_rdata;
   logic                 reg_rerr;

   dec_t                 w_dec;
   dec_t                 r_dec;
   logic [63:0]          wd64;
   logic [63:0]          wm64;
   logic [63:0]          rd_word;
   logic [15:0]          presc;
   logic                 tick;
   logic [63:0]          mtime;
   logic [NR_HARTS-1:0][63:0] cmp_all;

   clint_axil_slave #(
      .AXI_ADDR_WIDTH (AXI_ADDR_WIDTH),
      .AXI_DATA_WIDTH (AXI_DATA_WIDTH)
   ) u_slave (
      .aclk          (aclk),
      .areset        (areset),
      .s_axi_awaddr  (s_axi_awaddr),
      .s_axi_awvalid (s_axi_awvalid),
      .s_axi_awready (s_axi_awready),
      .s_axi_wdata   (s_axi_wdata),
      .s_axi_wstrb   (s_axi_wstrb),
      .s_axi_wvalid  (s_axi_wvalid),
      .s_axi_wready  (s_axi_wready),
      .s_axi_bresp   (s_axi_bresp),
      .s_axi_bvalid  (s_axi_bvalid),
      .s_axi_bready  (s_axi_bready),
      .s_axi_araddr  (s_axi_araddr),
      .s_axi_arvalid (s_axi_arvalid),
      .s_axi_arready (s_axi_arready),
      .s_axi_rdata   (s_axi_rdata),
      .s_axi_rresp   (s_axi_rresp),
      .s_axi_rvalid  (s_axi_rvalid),
      .s_axi_rready  (s_axi_rready),
      .reg_we        (reg_we),
      .reg_waddr     (reg_waddr),
      .reg_wdata     (reg_wdata),
      .reg_wstrb     (reg_wstrb),
      .reg_werr      (reg_werr),
      .reg_re        (reg_re),
      .reg_raddr     (reg_raddr),
      .reg_rdata     (reg_rdata),
      .reg_rerr      (reg_rerr)
   );

   assign w_dec = clint_decode(reg_waddr, DW, NR_HARTS);
   assign r_dec = clint_decode(reg_raddr, DW, NR_HARTS);

`ifdef CLINT_DECODE_ERR_EN
   assign reg_werr = (w_dec.sel == DEC_NONE);
   assign reg_rerr = (r_dec.sel == DEC_NONE);
`else
   assign reg_werr = 1'b0;
   assign reg_rerr = 1'b0;
`endif

   // Bus data is aligned onto a 64-bit register image; a 32-bit bus picks a half by addr[2].
   if (DW == 64) begin : g_bus64
      logic unused_lo;
      assign unused_lo = ^{reg_waddr[2:0], reg_raddr[2:0]};
      assign wd64      = reg_wdata;
      assign reg_rdata = rd_word;
      always_comb begin
         wm64 = '0;
         for (int b = 0; b < 8; b++) wm64[b*8 +: 8] = {8{reg_wstrb[b]}};
      end
   end else begin : g_bus32
      logic        unused_lo;
      logic [31:0] m32;
      assign unused_lo = ^{reg_waddr[1:0], reg_raddr[1:0]};
      assign wd64      = {reg_wdata, reg_wdata};
      assign wm64      = reg_waddr[2] ? {m32, 32'h0} : {32'h0, m32};
      assign reg_rdata = reg_raddr[2] ? rd_word[63:32] : rd_word[31:0];
      always_comb begin
         m32 = '0;
         for (int b = 0; b < 4; b++) m32[b*8 +: 8] = {8{reg_wstrb[b]}};
      end
   end

   assign tick = (presc == 16'(RTC_DIV - 1));

   // A bus write to mtime takes priority over the increment in the same cycle.
   always_ff @(posedge aclk) begin
      if (areset) begin
         presc <= '0;
         mtime <= '0;
      end else begin
         presc <= tick ? '0 : presc + 16'd1;
         if (reg_we && w_dec.sel == DEC_MTIME)
            mtime <= (mtime & ~wm64) | (wd64 & wm64);
         else if (tick)
            mtime <= mtime + 64'd1;
      end
   end

   for (genvar h = 0; h < NR_HARTS; h++) begin : g_hart
      localparam logic [12:0] WORD = 13'(h / 2);
      localparam int          LANE = (h % 2) * 32;
      logic        msip_q;
      logic        irq_q;
      logic [63:0] cmp_q;

      always_ff @(posedge aclk) begin
         if (areset) begin
            msip_q <= 1'b0;
            irq_q  <= 1'b0;
            cmp_q  <= '1;
         end else begin
            irq_q <= (mtime >= cmp_q);
            if (reg_we && w_dec.sel == DEC_MSIP && w_dec.idx == WORD && wm64[LANE])
               msip_q <= wd64[LANE];
            if (reg_we && w_dec.sel == DEC_MTIMECMP && w_dec.idx == 13'(h))
               cmp_q <= (cmp_q & ~wm64) | (wd64 & wm64);
         end
      end

      assign ipi_o[h]       = msip_q;
      assign timer_irq_o[h] = irq_q;
      assign cmp_all[h]     = cmp_q;
   end

   always_comb begin
      rd_word = '0;
      case (r_dec.sel)
         DEC_MSIP: begin
            for (int h = 0; h < NR_HARTS; h++) begin
               if (r_dec.idx == 13'(h / 2)) begin
                  if (h % 2 == 1) rd_word[32] = ipi_o[h];
                  else            rd_word[0]  = ipi_o[h];
               end
            end
         end
         DEC_MTIMECMP: begin
            for (int h = 0; h < NR_HARTS; h++)
               if (r_dec.idx == 13'(h)) rd_word = cmp_all[h];
         end
         DEC_MTIME: rd_word = mtime;
         default:   rd_word = '0;
      endcase
   end

endmodule

// File: tb/tb_clint_axil.sv
// Directed bench: a 64-bit/4-hart CLINT (RTC_DIV=2) and a 32-bit/2-hart CLINT (RTC_DIV=1).
module tb_clint_axil;

`ifdef CLINT_DECODE_ERR_EN
   localparam logic [1:0] ERR_RESP = 2'b10;
`else
   localparam logic [1:0] ERR_RESP = 2'b00;
`endif

   logic aclk = 1'b0;
   logic areset = 1'b1;
   always #5 aclk = ~aclk;

   logic [63:0] awaddr, araddr, wdata, rdata;
   logic [7:0]  wstrb;
   logic        awvalid, awready, wvalid, wready, bvalid, bready;
   logic        arvalid, arready, rvalid, rready;
   logic [1:0]  bresp, rresp;
   logic [3:0]  timer_irq, ipi;

   logic [31:0] m_awaddr, m_araddr, m_wdata, m_rdata;
   logic [3:0]  m_wstrb;
   logic        m_awvalid, m_awready, m_wvalid, m_wready, m_bvalid, m_bready;
   logic        m_arvalid, m_arready, m_rvalid, m_rready;
   logic [1:0]  m_bresp, m_rresp;
   logic [1:0]  m_timer_irq, m_ipi;

   clint_axil #(.NR_HARTS(4), .AXI_ADDR_WIDTH(64), .AXI_DATA_WIDTH(64), .RTC_DIV(2)) u64 (
      .aclk(aclk), .areset(areset),
      .s_axi_awaddr(awaddr), .s_axi_awvalid(awvalid), .s_axi_awready(awready),
      .s_axi_wdata(wdata), .s_axi_wstrb(wstrb), .s_axi_wvalid(wvalid), .s_axi_wready(wready),
      .s_axi_bresp(bresp), .s_axi_bvalid(bvalid), .s_axi_bready(bready),
      .s_axi_araddr(araddr), .s_axi_arvalid(arvalid), .s_axi_arready(arready),
      .s_axi_rdata(rdata), .s_axi_rresp(rresp), .s_axi_rvalid(rvalid), .s_axi_rready(rready),
      .timer_irq_o(timer_irq), .ipi_o(ipi));

   clint_axil #(.NR_HARTS(2), .AXI_ADDR_WIDTH(32), .AXI_DATA_WIDTH(32), .RTC_DIV(1)) u32 (
      .aclk(aclk), .areset(areset),
      .s_axi_awaddr(m_awaddr), .s_axi_awvalid(m_awvalid), .s_axi_awready(m_awready),
      .s_axi_wdata(m_wdata), .s_axi_wstrb(m_wstrb), .s_axi_wvalid(m_wvalid), .s_axi_wready(m_wready),
      .s_axi_bresp(m_bresp), .s_axi_bvalid(m_bvalid), .s_axi_bready(m_bready),
      .s_axi_araddr(m_araddr), .s_axi_arvalid(m_arvalid), .s_axi_arready(m_arready),
      .s_axi_rdata(m_rdata), .s_axi_rresp(m_rresp), .s_axi_rvalid(m_rvalid), .s_axi_rready(m_rready),
      .timer_irq_o(m_timer_irq), .ipi_o(m_ipi));

   int n_chk  = 0;
   int n_fail = 0;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic wr64(input logic [63:0] a, input logic [63:0] d, input logic [7:0] s,
                       output logic [1:0] resp, output logic [3:0] irq_b, output logic [3:0] ipi_b);
      int n = 0;
      logic a_hs, w_hs;
      @(negedge aclk);
      awaddr = a; awvalid = 1'b1; wdata = d; wstrb = s; wvalid = 1'b1; bready = 1'b1;
      while ((awvalid || wvalid) && n < 20) begin
         a_hs = awvalid && awready;
         w_hs = wvalid && wready;
         @(negedge aclk);
         if (a_hs) awvalid = 1'b0;
         if (w_hs) wvalid = 1'b0;
         n++;
      end
      while (!bvalid && n < 40) begin @(negedge aclk); n++; end
      check("wr64_bvalid", {63'b0, bvalid}, 64'd1);
      resp = bresp; irq_b = timer_irq; ipi_b = ipi;
      @(negedge aclk);
      bready = 1'b0; awvalid = 1'b0; wvalid = 1'b0;
   endtask

   task automatic rd64(input logic [63:0] a, output logic [63:0] d, output logic [1:0] resp);
      int n = 0;
      logic hs = 1'b0;
      @(negedge aclk);
      araddr = a; arvalid = 1'b1; rready = 1'b0;
      while (!hs && n < 20) begin hs = arready; @(negedge aclk); n++; end
      arvalid = 1'b0;
      check("rd64_latency", {63'b0, rvalid}, 64'd1);
      d = rdata; resp = rresp;
      rready = 1'b1;
      @(negedge aclk);
      rready = 1'b0;
   endtask

   task automatic wr32(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                       output logic [1:0] resp);
      int n = 0;
      logic a_hs, w_hs;
      @(negedge aclk);
      m_awaddr = a; m_awvalid = 1'b1; m_wdata = d; m_wstrb = s; m_wvalid = 1'b1; m_bready = 1'b1;
      while ((m_awvalid || m_wvalid) && n < 20) begin
         a_hs = m_awvalid && m_awready;
         w_hs = m_wvalid && m_wready;
         @(negedge aclk);
         if (a_hs) m_awvalid = 1'b0;
         if (w_hs) m_wvalid = 1'b0;
         n++;
      end
      while (!m_bvalid && n < 40) begin @(negedge aclk); n++; end
      check("wr32_bvalid", {63'b0, m_bvalid}, 64'd1);
      resp = m_bresp;
      @(negedge aclk);
      m_bready = 1'b0; m_awvalid = 1'b0; m_wvalid = 1'b0;
   endtask

   task automatic rd32(input logic [31:0] a, output logic [31:0] d, output logic [1:0] resp);
      int n = 0;
      logic hs = 1'b0;
      @(negedge aclk);
      m_araddr = a; m_arvalid = 1'b1; m_rready = 1'b0;
      while (!hs && n < 20) begin hs = m_arready; @(negedge aclk); n++; end
      m_arvalid = 1'b0;
      check("rd32_latency", {63'b0, m_rvalid}, 64'd1);
      d = m_rdata; resp = m_rresp;
      m_rready = 1'b1;
      @(negedge aclk);
      m_rready = 1'b0;
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [63:0] v, m;
      logic [31:0] v32;
      logic [1:0]  r;
      logic [3:0]  irq_b, ipi_b;
      int          n;

      awaddr = '0; araddr = '0; wdata = '0; wstrb = '0;
      awvalid = 1'b0; wvalid = 1'b0; bready = 1'b0; arvalid = 1'b0; rready = 1'b0;
      m_awaddr = '0; m_araddr = '0; m_wdata = '0; m_wstrb = '0;
      m_awvalid = 1'b0; m_wvalid = 1'b0; m_bready = 1'b0; m_arvalid = 1'b0; m_rready = 1'b0;

      // reset state
      repeat (3) @(negedge aclk);
      check("rst_ready", {61'b0, awready, wready, arready}, 64'h7);
      check("rst_valid", {62'b0, bvalid, rvalid}, 64'h0);
      check("rst_resp", {60'b0, bresp, rresp}, 64'h0);
      check("rst_rdata", rdata, 64'h0);
      check("rst_irq_ipi", {56'b0, timer_irq, ipi}, 64'h0);
      check("rst32_ready", {61'b0, m_awready, m_wready, m_arready}, 64'h7);
      check("rst32_rdata", {32'b0, m_rdata}, 64'h0);
      areset = 1'b0;

      // mtime runs at aclk/2; no interrupts while idle
      for (int i = 0; i < 20; i++) begin
         @(negedge aclk);
         check("idle_irq_ipi", {56'b0, timer_irq, ipi}, 64'h0);
      end
      rd64(64'hBFF8, v, r);
      check("mtime_after_20", {63'b0, (v >= 64'd9 && v <= 64'd11)}, 64'd1);
      check("mtime_resp", {62'b0, r}, 64'h0);

      // msip, both lanes of one 64-bit word
      wr64(64'h0008, 64'hFFFF_FFFF, 8'h0F, r, irq_b, ipi_b);
      check("msip2_bresp", {62'b0, r}, 64'h0);
      check("msip2_ipi_at_b", {60'b0, ipi_b}, 64'h4);
      check("msip2_ipi", {60'b0, ipi}, 64'h4);
      rd64(64'h0008, v, r);
      check("msip2_read", v, 64'h1);
      wr64(64'h000C, 64'h1_0000_0000, 8'hF0, r, irq_b, ipi_b);
      check("msip3_ipi", {60'b0, ipi}, 64'hC);
      rd64(64'h0008, v, r);
      check("msip23_read", v, 64'h0000_0001_0000_0001);
      wr64(64'h0008, 64'h0, 8'h0F, r, irq_b, ipi_b);
      check("msip2_clear", {60'b0, ipi}, 64'h8);

      // hart index past NR_HARTS
      wr64(64'h0010, 64'h1_0000_0001, 8'hFF, r, irq_b, ipi_b);
      check("msip_oor_bresp", {62'b0, r}, {62'b0, ERR_RESP});
      check("msip_oor_ipi", {60'b0, ipi}, 64'h8);
      rd64(64'h0010, v, r);
      check("msip_oor_rdata", v, 64'h0);
      check("msip_oor_rresp", {62'b0, r}, {62'b0, ERR_RESP});

      // mtimecmp[1] = mtime + 5, then back to all-ones
      rd64(64'hBFF8, m, r);
      wr64(64'h4008, m + 64'd5, 8'hFF, r, irq_b, ipi_b);
      check("cmp1_irq_at_b", {60'b0, irq_b}, 64'h0);
      check("cmp1_irq_early", {60'b0, timer_irq}, 64'h0);
      n = 0;
      while (!timer_irq[1] && n < 16) begin @(negedge aclk); n++; end
      check("cmp1_irq_rise", {60'b0, timer_irq}, 64'h2);
      wr64(64'h4008, 64'hFFFF_FFFF_FFFF_FFFF, 8'hFF, r, irq_b, ipi_b);
      check("cmp1_irq_hold", {60'b0, irq_b}, 64'h2);
      check("cmp1_irq_drop", {60'b0, timer_irq}, 64'h0);

      // W three cycles ahead of AW, then bready held low
      @(negedge aclk);
      wdata = 64'h1234; wstrb = 8'hFF; wvalid = 1'b1;
      @(negedge aclk);
      wvalid = 1'b0;
      check("race_w_latched", {63'b0, wready}, 64'd0);
      @(negedge aclk);
      @(negedge aclk);
      check("race_no_commit", {63'b0, bvalid}, 64'd0);
      awaddr = 64'h4010; awvalid = 1'b1;
      @(negedge aclk);
      awvalid = 1'b0;
      @(negedge aclk);
      check("race_bvalid", {62'b0, bvalid, bresp[1]}, 64'h2);
      for (int i = 0; i < 4; i++) begin
         @(negedge aclk);
         check("race_hold", {61'b0, bvalid, awready, wready}, 64'h4);
      end
      bready = 1'b1;
      @(negedge aclk);
      bready = 1'b0;
      check("race_release", {61'b0, bvalid, awready, wready}, 64'h3);
      rd64(64'h4010, v, r);
      check("race_cmp2", v, 64'h1234);

      // byte strobe on mtimecmp[0]
      wr64(64'h4000, 64'h0, 8'h01, r, irq_b, ipi_b);
      rd64(64'h4000, v, r);
      check("cmp0_strb", v, 64'hFFFF_FFFF_FFFF_FF00);

      // mtime carry across bit 32
      wr64(64'hBFF8, 64'h1_FFFF_FFFE, 8'hFF, r, irq_b, ipi_b);
      rd64(64'hBFF8, v, r);
      check("mtime_wr", {63'b0, (v == 64'h1_FFFF_FFFE || v == 64'h1_FFFF_FFFF)}, 64'd1);
      repeat (6) @(negedge aclk);
      rd64(64'hBFF8, v, r);
      check("mtime_carry", {32'b0, v[63:32]}, 64'h2);

      rd64(64'h8000, v, r);
      check("unmapped_rdata", v, 64'h0);
      check("unmapped_rresp", {62'b0, r}, {62'b0, ERR_RESP});

      // 32-bit bus
      wr32(32'hBFFC, 32'h1, 4'hF, r);
      wr32(32'hBFF8, 32'hFFFF_FFFE, 4'hF, r);
      repeat (4) @(negedge aclk);
      rd32(32'hBFFC, v32, r);
      check("m_mtime_hi", {32'b0, v32}, 64'h2);
      rd32(32'hBFF8, v32, r);
      check("m_mtime_lo_small", {63'b0, (v32 < 32'h20)}, 64'd1);
      wr32(32'h4000, 32'h0, 4'h1, r);
      rd32(32'h4000, v32, r);
      check("m_cmp0_lo", {32'b0, v32}, 64'hFFFF_FF00);
      rd32(32'h4004, v32, r);
      check("m_cmp0_hi", {32'b0, v32}, 64'hFFFF_FFFF);
      wr32(32'h400C, 32'hAABB_CCDD, 4'hF, r);
      rd32(32'h400C, v32, r);
      check("m_cmp1_hi", {32'b0, v32}, 64'hAABB_CCDD);
      rd32(32'h4008, v32, r);
      check("m_cmp1_lo", {32'b0, v32}, 64'hFFFF_FFFF);
      wr32(32'h0004, 32'hFFFF_FFFF, 4'hF, r);
      check("m_msip1_ipi", {62'b0, m_ipi}, 64'h2);
      rd32(32'h0004, v32, r);
      check("m_msip1_read", {32'b0, v32}, 64'h1);
      rd32(32'h0000, v32, r);
      check("m_msip0_read", {32'b0, v32}, 64'h0);
      wr32(32'h0008, 32'h1, 4'hF, r);
      check("m_msip_oor_bresp", {62'b0, r}, {62'b0, ERR_RESP});
      check("m_msip_oor_ipi", {62'b0, m_ipi}, 64'h2);
      rd32(32'h8000, v32, r);
      check("m_unmapped_rdata", {32'b0, v32}, 64'h0);
      check("m_unmapped_rresp", {62'b0, r}, {62'b0, ERR_RESP});

      // reset with a read response outstanding
      @(negedge aclk);
      araddr = 64'hBFF8; arvalid = 1'b1; rready = 1'b0;
      @(negedge aclk);
      arvalid = 1'b0;
      check("midrst_rvalid_pre", {63'b0, rvalid}, 64'd1);
      areset = 1'b1;
      @(negedge aclk);
      check("midrst_r", {62'b0, rvalid, arready}, 64'h1);
      check("midrst_ipi", {58'b0, ipi, m_ipi}, 64'h0);
      check("midrst_rdata", rdata, 64'h0);
      areset = 1'b0;
      @(negedge aclk);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
